// File: rtl/fofir_tap_sched.sv
// Tap/bit-pair sequencer for one FoFIR processing element: drives the PAMAC, DReg write-back and output load.
// Optional zero-activation skip is enabled by defining FOFIR_TAP_SCHED_ZERO_SKIP_EN.
module fofir_tap_sched #(
    parameter int NB_TAPS = 5,
    parameter int TAP_W   = 3,
    parameter int NAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               act_valid,
    output logic               act_ready,
    input  logic               act_is_zero,
    input  logic [NAP_W-1:0]   n_ap,
    input  logic [TAP_W-1:0]   PD0,
    output logic [TAP_W-1:0]   current_tap,
    output logic [2:0]         PAMAC_BPEB_sel,
    output logic               PAMAC_DFF_en,
    output logic               PAMAC_first_cycle,
    output logic [NB_TAPS-1:0] DRegs_en,
    output logic [NB_TAPS-1:0] DRegs_in_sel,
    output logic [NB_TAPS-1:0] DRegs_clr,
    output logic               index_update_en,
    output logic               out_mux_sel,
    output logic               out_reg_en,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [NAP_W-1:0]   nap_q, nap_d;
    logic [NAP_W-1:0]   bp_q, bp_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               zero_skip;
    logic [TAP_W:0]     phys_sum;
    logic [TAP_W-1:0]   phys;
    logic [NB_TAPS-1:0] phys_hot;
    logic [NB_TAPS-1:0] pd0_hot;

`ifdef FOFIR_TAP_SCHED_ZERO_SKIP_EN
    assign zero_skip = act_is_zero;
`else
    logic unused_act_is_zero;
    assign unused_act_is_zero = act_is_zero;
    assign zero_skip          = 1'b0;
`endif

    // Held result blocks new work so an unread output is never overwritten.
    assign act_ready = (state_q == S_IDLE) && !(out_valid_q && !out_ready);
    assign accept    = act_valid && act_ready;
    assign out_valid = out_valid_q;

    // Logical tap to physical DReg: tap + PD0 < 2*NB_TAPS, so one subtract suffices.
    assign phys_sum = {1'b0, tap_q} + {1'b0, PD0};
    assign phys     = (phys_sum >= (TAP_W+1)'(NB_TAPS))
                    ? TAP_W'(phys_sum - (TAP_W+1)'(NB_TAPS))
                    : TAP_W'(phys_sum);

    generate
        for (genvar gi = 0; gi < NB_TAPS; gi++) begin : g_hot
            assign phys_hot[gi] = (phys == TAP_W'(gi));
            assign pd0_hot[gi]  = (PD0 == TAP_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d           = state_q;
        nap_d             = nap_q;
        bp_d              = bp_q;
        tap_d             = tap_q;
        current_tap       = '0;
        PAMAC_BPEB_sel    = 3'd0;
        PAMAC_DFF_en      = 1'b0;
        PAMAC_first_cycle = 1'b0;
        DRegs_en          = '0;
        DRegs_in_sel      = '0;
        DRegs_clr         = '0;
        index_update_en   = 1'b0;
        out_mux_sel       = 1'b0;
        out_reg_en        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    nap_d   = (n_ap == '0) ? NAP_W'(1) : n_ap;
                    tap_d   = '0;
                    bp_d    = '0;
                    state_d = zero_skip ? S_OUT : S_MAC;
                end
            end
            S_MAC: begin
                PAMAC_DFF_en      = 1'b1;
                PAMAC_BPEB_sel    = bp_q[2:0];
                PAMAC_first_cycle = (bp_q == '0);
                current_tap       = tap_q;
                if (bp_q == nap_q - NAP_W'(1)) begin
                    state_d = S_WB;
                end else begin
                    bp_d = bp_q + NAP_W'(1);
                end
            end
            S_WB: begin
                current_tap  = tap_q;
                DRegs_en     = phys_hot;
                DRegs_in_sel = phys_hot;
                if (tap_q == TAP_W'(NB_TAPS - 1)) begin
                    state_d = S_OUT;
                end else begin
                    tap_d   = tap_q + TAP_W'(1);
                    bp_d    = '0;
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                out_mux_sel     = 1'b1;
                out_reg_en      = 1'b1;
                DRegs_clr       = pd0_hot;
                index_update_en = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A fresh result takes priority over a consume in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        if (state_q == S_OUT) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nap_q       <= '0;
            bp_q        <= '0;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nap_q       <= nap_d;
            bp_q        <= bp_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fofir_tap_sched.sv
// Directed bench for fofir_tap_sched: per-cycle schedule checks against a cycle model
// derived from the tap/bit-pair timing, plus reset, back-pressure and zero-activation cases.
module tb_fofir_tap_sched;

    localparam int NB    = 5;
    localparam int TAP_W = 3;
    localparam int NAP_W = 4;
`ifdef FOFIR_TAP_SCHED_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             act_valid;
    logic             act_ready;
    logic             act_is_zero;
    logic [NAP_W-1:0] n_ap;
    logic [TAP_W-1:0] PD0;
    logic [TAP_W-1:0] current_tap;
    logic [2:0]       PAMAC_BPEB_sel;
    logic             PAMAC_DFF_en;
    logic             PAMAC_first_cycle;
    logic [NB-1:0]    DRegs_en;
    logic [NB-1:0]    DRegs_in_sel;
    logic [NB-1:0]    DRegs_clr;
    logic             index_update_en;
    logic             out_mux_sel;
    logic             out_reg_en;
    logic             out_valid;
    logic             out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fofir_tap_sched #(.NB_TAPS(NB), .TAP_W(TAP_W), .NAP_W(NAP_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .act_valid         (act_valid),
        .act_ready         (act_ready),
        .act_is_zero       (act_is_zero),
        .n_ap              (n_ap),
        .PD0               (PD0),
        .current_tap       (current_tap),
        .PAMAC_BPEB_sel    (PAMAC_BPEB_sel),
        .PAMAC_DFF_en      (PAMAC_DFF_en),
        .PAMAC_first_cycle (PAMAC_first_cycle),
        .DRegs_en          (DRegs_en),
        .DRegs_in_sel      (DRegs_in_sel),
        .DRegs_clr         (DRegs_clr),
        .index_update_en   (index_update_en),
        .out_mux_sel       (out_mux_sel),
        .out_reg_en        (out_reg_en),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one activation at the current negedge and follow it to completion.
    // Cycle c counts clock edges after the accepting edge; the result appears at c == L.
    task automatic run_act(input int pd0, input int nap, input bit zero);
        int e, L, k, tp, p;
        bit skip;
        logic [31:0] e_dff, e_bp, e_first, e_tap, e_en, e_clr, e_out, e_ov, e_rdy;
        e    = (nap == 0) ? 1 : nap;
        skip = zero && ZS;
        L    = skip ? 2 : NB * (e + 1) + 2;
        PD0         = TAP_W'(pd0);
        n_ap        = NAP_W'(nap);
        act_is_zero = zero;
        act_valid   = 1'b1;
        #1;
        chk("accept_ready", act_ready, 1);
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            act_valid = 1'b0;
            e_dff = 0; e_bp = 0; e_first = 0; e_tap = 0; e_en = 0;
            e_clr = 0; e_out = 0; e_ov = 0; e_rdy = 0;
            if (c == L) begin
                e_ov  = 1;
                e_rdy = out_ready;
            end else if (c == L - 1) begin
                e_out = 1;
                e_clr = 32'd1 << pd0;
            end else begin
                k     = c - 1;
                tp    = k / (e + 1);
                p     = k % (e + 1);
                e_tap = tp;
                if (p < e) begin
                    e_dff   = 1;
                    e_bp    = p;
                    e_first = (p == 0);
                end else begin
                    e_en = 32'd1 << ((tp + pd0) % NB);
                end
            end
            chk($sformatf("c%0d dff_en", c), PAMAC_DFF_en, e_dff);
            chk($sformatf("c%0d bpeb_sel", c), PAMAC_BPEB_sel, e_bp);
            chk($sformatf("c%0d first_cycle", c), PAMAC_first_cycle, e_first);
            chk($sformatf("c%0d current_tap", c), current_tap, e_tap);
            chk($sformatf("c%0d dregs_en", c), DRegs_en, e_en);
            chk($sformatf("c%0d dregs_in_sel", c), DRegs_in_sel, e_en);
            chk($sformatf("c%0d dregs_clr", c), DRegs_clr, e_clr);
            chk($sformatf("c%0d out_reg_en", c), out_reg_en, e_out);
            chk($sformatf("c%0d out_mux_sel", c), out_mux_sel, e_out);
            chk($sformatf("c%0d index_update", c), index_update_en, e_out);
            chk($sformatf("c%0d out_valid", c), out_valid, e_ov);
            chk($sformatf("c%0d act_ready", c), act_ready, e_rdy);
        end
        @(negedge clk);
        chk("post_out_valid", out_valid, !out_ready);
        chk("post_act_ready", act_ready, out_ready);
        $display("act pd0=%0d n_ap=%0d zero=%0b latency=%0d out_ready=%0b errors=%0d",
                 pd0, nap, zero, L, out_ready, errors);
    endtask

    initial begin
        rst_n = 1'b0; act_valid = 1'b0; act_is_zero = 1'b0;
        n_ap = '0; PD0 = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst act_ready", act_ready, 1);
        chk("rst dff_en", PAMAC_DFF_en, 0);
        chk("rst dregs_en", DRegs_en, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_reg_en", out_reg_en, 0);
        $display("reset released");
        rst_n = 1'b1;
        @(negedge clk);

        run_act(0, 3, 1'b0);   // full schedule, latency 22
        run_act(0, 0, 1'b0);   // n_ap 0 behaves as 1, latency 12
        run_act(3, 1, 1'b0);   // PD0 wrap: tap 2 -> DReg 0
        run_act(4, 2, 1'b0);

        // Back-pressure: unread result blocks the next activation.
        out_ready = 1'b0;
        run_act(1, 1, 1'b0);
        act_valid = 1'b1; n_ap = 4'd2; PD0 = 3'd2; act_is_zero = 1'b0;
        #1;
        chk("bp act_ready", act_ready, 0);
        @(negedge clk);
        chk("bp hold act_ready", act_ready, 0);
        chk("bp hold out_valid", out_valid, 1);
        chk("bp hold dff_en", PAMAC_DFF_en, 0);
        $display("backpressure hold checked");
        out_ready = 1'b1;
        run_act(2, 2, 1'b0);

        // Asynchronous reset in the middle of MAC.
        act_valid = 1'b1; n_ap = 4'd3; PD0 = 3'd0;
        @(negedge clk);
        act_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst bpeb_sel", PAMAC_BPEB_sel, 1);
        chk("pre_rst dff_en", PAMAC_DFF_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst dff_en", PAMAC_DFF_en, 0);
        chk("mid_rst bpeb_sel", PAMAC_BPEB_sel, 0);
        chk("mid_rst first", PAMAC_first_cycle, 0);
        chk("mid_rst act_ready", act_ready, 1);
        chk("mid_rst dregs_en", DRegs_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst dff_en", PAMAC_DFF_en, 0);
        chk("after_rst act_ready", act_ready, 1);
        chk("after_rst out_valid", out_valid, 0);
        $display("mid-MAC reset checked");

        run_act(2, 3, 1'b1);   // zero activation: skipped only when the option is built in

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
